// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ControlUnit bundle, NOP control word and opcodes.
// Also holds a helper that turns unknown control bits into zeros.
package mips_pkg;

    typedef struct packed {
        logic       RegDst;
        logic       Branch;
        logic       MemRead;
        logic       MemtoReg;
        logic [3:0] ALUOp;
        logic       MemWrite;
        logic       ALUSrc;
        logic       RegWrite;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = ctrl_t'(11'b000_0000_0000);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ControlUnit leaves RegDst/MemtoReg as x for stores; only a definite 1 survives.
    function automatic ctrl_t cleanCtrl(input ctrl_t c);
        logic [CTRL_W-1:0] bits;
        bits = c;
        for (int i = 0; i < CTRL_W; i++) begin
            bits[i] = (bits[i] === 1'b1);
        end
        return ctrl_t'(bits);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the ID operands.
// A load targeting $zero never creates a dependency.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              idValid,
    input  logic              exValid,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRt,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    output logic              hz
);

    logic rtNonZero_s;
    logic rtMatch_s;

    // Combinational dependency check.
    always_comb begin
        rtNonZero_s = (exRt != {REG_AW{1'b0}});
        rtMatch_s   = (exRt == idRs) || (exRt == idRt);
        hz          = idValid & exValid & exMemRead & rtNonZero_s & rtMatch_s;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures control and operands, inserts bubbles on
// load-use hazards or branch flush, freezes on MEM hold, counts bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_RegDst,
    input  logic              id_Branch,
    input  logic              id_MemRead,
    input  logic              id_MemtoReg,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegWrite,
    input  logic [3:0]        id_ALUOp,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              ex_flush,
    input  logic              mem_hold,
    output logic              hz_stall,
    output logic              ex_valid,
    output logic              ex_RegDst,
    output logic              ex_Branch,
    output logic              ex_MemRead,
    output logic              ex_MemtoReg,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic              ex_RegWrite,
    output logic [3:0]        ex_ALUOp,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              exValid_r;
    ctrl_t             exCtrl_r;
    logic [REG_AW-1:0] exRs_r;
    logic [REG_AW-1:0] exRt_r;
    logic [REG_AW-1:0] exRd_r;
    logic [REG_AW-1:0] exWreg_r;
    logic [DATA_W-1:0] exRsData_r;
    logic [DATA_W-1:0] exRtData_r;
    logic [DATA_W-1:0] exImm_r;
    logic [DATA_W-1:0] exPc4_r;
    logic [CNT_W-1:0]  bubbleCnt_r;

    ctrl_t             idCtrlRaw_s;
    ctrl_t             idCtrl_s;
    logic [REG_AW-1:0] idWreg_s;
    logic              hz_s;
    logic              bubble_s;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .idValid   (id_valid),
        .exValid   (exValid_r),
        .exMemRead (exCtrl_r.MemRead),
        .exRt      (exRt_r),
        .idRs      (id_rs),
        .idRt      (id_rt),
        .hz        (hz_s)
    );

    // Incoming control word (zeroed when ID is empty), destination select and stall.
    always_comb begin
        idCtrlRaw_s = '{RegDst:   id_RegDst,
                        Branch:   id_Branch,
                        MemRead:  id_MemRead,
                        MemtoReg: id_MemtoReg,
                        ALUOp:    id_ALUOp,
                        MemWrite: id_MemWrite,
                        ALUSrc:   id_ALUSrc,
                        RegWrite: id_RegWrite};
        if (id_valid) begin
            idCtrl_s = cleanCtrl(idCtrlRaw_s);
        end else begin
            idCtrl_s = CTRL_NOP;
        end
        if (idCtrl_s.RegDst) begin
            idWreg_s = id_rd;
        end else begin
            idWreg_s = id_rt;
        end
        // A taken branch redirects IF, so neither hazard nor hold may stall it.
        hz_stall = (hz_s | mem_hold) & ~ex_flush;
        bubble_s = ex_flush | (~mem_hold & hz_s);
    end

    // Pipeline register with flush > hold > hazard > load priority.
    always_ff @(posedge clk) begin
        if (rst || bubble_s) begin
            exValid_r  <= 1'b0;
            exCtrl_r   <= CTRL_NOP;
            exRs_r     <= {REG_AW{1'b0}};
            exRt_r     <= {REG_AW{1'b0}};
            exRd_r     <= {REG_AW{1'b0}};
            exWreg_r   <= {REG_AW{1'b0}};
            exRsData_r <= {DATA_W{1'b0}};
            exRtData_r <= {DATA_W{1'b0}};
            exImm_r    <= {DATA_W{1'b0}};
            exPc4_r    <= {DATA_W{1'b0}};
            if (rst) begin
                bubbleCnt_r <= {CNT_W{1'b0}};
            end else if (!ex_flush && (bubbleCnt_r != CNT_MAX)) begin
                bubbleCnt_r <= bubbleCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bubbleCnt_r <= bubbleCnt_r;
            end
        end else if (mem_hold) begin
            bubbleCnt_r <= bubbleCnt_r;
        end else begin
            exValid_r   <= id_valid;
            exCtrl_r    <= idCtrl_s;
            exRs_r      <= id_rs;
            exRt_r      <= id_rt;
            exRd_r      <= id_rd;
            exWreg_r    <= idWreg_s;
            exRsData_r  <= id_rs_data;
            exRtData_r  <= id_rt_data;
            exImm_r     <= id_imm;
            exPc4_r     <= id_pc4;
            bubbleCnt_r <= bubbleCnt_r;
        end
    end

    assign ex_valid    = exValid_r;
    assign ex_RegDst   = exCtrl_r.RegDst;
    assign ex_Branch   = exCtrl_r.Branch;
    assign ex_MemRead  = exCtrl_r.MemRead;
    assign ex_MemtoReg = exCtrl_r.MemtoReg;
    assign ex_MemWrite = exCtrl_r.MemWrite;
    assign ex_ALUSrc   = exCtrl_r.ALUSrc;
    assign ex_RegWrite = exCtrl_r.RegWrite;
    assign ex_ALUOp    = exCtrl_r.ALUOp;
    assign ex_rs       = exRs_r;
    assign ex_rt       = exRt_r;
    assign ex_rd       = exRd_r;
    assign ex_wreg     = exWreg_r;
    assign ex_rs_data  = exRsData_r;
    assign ex_rt_data  = exRtData_r;
    assign ex_imm      = exImm_r;
    assign ex_pc4      = exPc4_r;
    assign bubble_cnt  = bubbleCnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts the next EX
// state each cycle, queues it, and the queued entry is compared after the edge.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] wreg;
        logic [DATA_W-1:0] rsd;
        logic [DATA_W-1:0] rtd;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              idValid;
    ctrl_t             idCtrl;
    logic [REG_AW-1:0] idRs, idRt, idRd;
    logic [DATA_W-1:0] idRsData, idRtData, idImm, idPc4;
    logic              exFlush, memHold;

    logic              hzStall, exValid;
    logic              exRegDst, exBranch, exMemRead, exMemtoReg, exMemWrite, exALUSrc, exRegWrite;
    logic [3:0]        exALUOp;
    logic [REG_AW-1:0] exRs, exRt, exRd, exWreg;
    logic [DATA_W-1:0] exRsData, exRtData, exImm, exPc4;
    logic [CNT_W-1:0]  bubbleCnt;

    int   vecCnt = 0;
    int   errCnt = 0;
    exp_t model;
    exp_t sbQ[$];

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(idValid),
        .id_RegDst(idCtrl.RegDst), .id_Branch(idCtrl.Branch), .id_MemRead(idCtrl.MemRead),
        .id_MemtoReg(idCtrl.MemtoReg), .id_MemWrite(idCtrl.MemWrite), .id_ALUSrc(idCtrl.ALUSrc),
        .id_RegWrite(idCtrl.RegWrite), .id_ALUOp(idCtrl.ALUOp),
        .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
        .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm(idImm), .id_pc4(idPc4),
        .ex_flush(exFlush), .mem_hold(memHold), .hz_stall(hzStall), .ex_valid(exValid),
        .ex_RegDst(exRegDst), .ex_Branch(exBranch), .ex_MemRead(exMemRead),
        .ex_MemtoReg(exMemtoReg), .ex_MemWrite(exMemWrite), .ex_ALUSrc(exALUSrc),
        .ex_RegWrite(exRegWrite), .ex_ALUOp(exALUOp),
        .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd),
        .ex_rs_data(exRsData), .ex_rt_data(exRtData), .ex_imm(exImm), .ex_pc4(exPc4),
        .ex_wreg(exWreg), .bubble_cnt(bubbleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t mkCtrl(input logic regDst, input logic branch, input logic memRead,
                                     input logic memtoReg, input logic [3:0] aluOp,
                                     input logic memWrite, input logic aluSrc, input logic regWrite);
        return '{RegDst: regDst, Branch: branch, MemRead: memRead, MemtoReg: memtoReg,
                 ALUOp: aluOp, MemWrite: memWrite, ALUSrc: aluSrc, RegWrite: regWrite};
    endfunction

    ctrl_t cR, cLw, cSw, cBeq;

    task automatic setInstr(input logic v, input ctrl_t c, input logic [REG_AW-1:0] rs,
                            input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
        idValid  = v;
        idCtrl   = c;
        idRs     = rs;
        idRt     = rt;
        idRd     = rd;
        idRsData = $urandom;
        idRtData = $urandom;
        idImm    = $urandom;
        idPc4    = $urandom;
    endtask

    // Predict, drive one clock, then pop the prediction and compare every output.
    task automatic cycle(input string tag);
        exp_t  e;
        ctrl_t obsCtrl;
        logic  mhz;
        #1;
        mhz = idValid & model.valid & model.ctrl.MemRead & (model.rt != 5'd0)
              & ((model.rt == idRs) | (model.rt == idRt));
        checkVal({tag, ":hz_stall"}, 64'(hzStall), 64'((mhz | memHold) & ~exFlush));
        e = model;
        if (rst) begin
            e = '0;
        end else if (exFlush || (!memHold && mhz)) begin
            e     = '0;
            e.cnt = model.cnt;
            if (!exFlush && model.cnt != 4'hF) e.cnt = model.cnt + 4'd1;
        end else if (memHold) begin
            e = model;
        end else begin
            e.valid = idValid;
            e.ctrl  = idValid ? idCtrl : ctrl_t'(11'd0);
            e.rs    = idRs;
            e.rt    = idRt;
            e.rd    = idRd;
            e.wreg  = (idValid & idCtrl.RegDst) ? idRd : idRt;
            e.rsd   = idRsData;
            e.rtd   = idRtData;
            e.imm   = idImm;
            e.pc4   = idPc4;
        end
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        e       = sbQ.pop_front();
        model   = e;
        obsCtrl = mkCtrl(exRegDst, exBranch, exMemRead, exMemtoReg, exALUOp, exMemWrite, exALUSrc, exRegWrite);
        checkVal({tag, ":valid"}, 64'(exValid), 64'(e.valid));
        checkVal({tag, ":ctrl"},  64'(obsCtrl), 64'(e.ctrl));
        checkVal({tag, ":regs"},  64'({exRs, exRt, exRd, exWreg}), 64'({e.rs, e.rt, e.rd, e.wreg}));
        checkVal({tag, ":rsd"},   64'(exRsData), 64'(e.rsd));
        checkVal({tag, ":rtd"},   64'(exRtData), 64'(e.rtd));
        checkVal({tag, ":imm"},   64'(exImm), 64'(e.imm));
        checkVal({tag, ":pc4"},   64'(exPc4), 64'(e.pc4));
        checkVal({tag, ":cnt"},   64'(bubbleCnt), 64'(e.cnt));
    endtask

    initial begin
        cR   = mkCtrl(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
        cLw  = mkCtrl(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
        cSw  = mkCtrl(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        cBeq = mkCtrl(1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);

        // Reset with every id_* input driven to ones.
        rst = 1'b1; exFlush = 1'b0; memHold = 1'b0;
        idValid = 1'b1; idCtrl = ctrl_t'(11'h7FF);
        idRs = 5'h1F; idRt = 5'h1F; idRd = 5'h1F;
        idRsData = 32'hFFFF_FFFF; idRtData = 32'hFFFF_FFFF; idImm = 32'hFFFF_FFFF; idPc4 = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        model = '0;
        cycle("reset");
        rst = 1'b0;

        // R-type enters EX one cycle later.
        setInstr(1'b1, cR, 5'd1, 5'd2, 5'd3); cycle("rtype");
        checkVal("rtype_wreg", 64'(exWreg), 64'd3);
        checkVal("rtype_aluop", 64'(exALUOp), 64'h2);

        // Load-use: one bubble, then the dependent add enters.
        setInstr(1'b1, cLw, 5'd0, 5'd5, 5'd0); cycle("lw5");
        setInstr(1'b1, cR, 5'd5, 5'd7, 5'd8);  cycle("ldUseStall");
        checkVal("ldUse_regwrite", 64'(exRegWrite), 64'd0);
        checkVal("ldUse_cnt", 64'(bubbleCnt), 64'd1);
        cycle("ldUseRetry");
        checkVal("ldUse_enter_rs", 64'(exRs), 64'd5);

        // $zero load and independent operands do not stall.
        setInstr(1'b1, cLw, 5'd0, 5'd0, 5'd0); cycle("lw0");
        setInstr(1'b1, cR, 5'd0, 5'd3, 5'd4);  cycle("zeroReg");
        setInstr(1'b1, cLw, 5'd0, 5'd5, 5'd0); cycle("lw5b");
        setInstr(1'b1, cR, 5'd4, 5'd6, 5'd9);  cycle("noDep");

        // Flush beats hazard and hold, and does not count.
        setInstr(1'b1, cLw, 5'd0, 5'd5, 5'd0); cycle("lw5c");
        setInstr(1'b1, cR, 5'd5, 5'd1, 5'd2);
        exFlush = 1'b1; memHold = 1'b1;        cycle("flushAll");
        exFlush = 1'b0; memHold = 1'b0;
        setInstr(1'b1, cSw, 5'd1, 5'd2, 5'd0); cycle("store");
        setInstr(1'b1, cBeq, 5'd3, 5'd4, 5'd0); cycle("branch");
        setInstr(1'b0, cR, 5'd6, 5'd7, 5'd8);  cycle("invalidId");

        // Hold freezes EX while ID changes.
        setInstr(1'b1, cR, 5'd1, 5'd2, 5'd3); cycle("preHold");
        memHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setInstr(1'b1, cLw, 5'(i + 10), 5'(i + 20), 5'(i + 4));
            cycle("hold");
        end
        memHold = 1'b0;
        cycle("postHold");

        // Reset while a stall is pending.
        setInstr(1'b1, cLw, 5'd0, 5'd5, 5'd0); cycle("lw5d");
        setInstr(1'b1, cR, 5'd5, 5'd7, 5'd8);
        rst = 1'b1; cycle("rstMid");
        rst = 1'b0; cycle("afterRst");

        // Drive the counter to saturation and beyond.
        for (int i = 0; i < 18; i++) begin
            setInstr(1'b1, cLw, 5'd0, 5'd5, 5'd0); cycle("satLw");
            setInstr(1'b1, cR, 5'd5, 5'd5, 5'd9);  cycle("satStall");
            cycle("satRetry");
        end
        checkVal("satCnt", 64'(bubbleCnt), 64'hF);

        // Randomized mix on a small register range to provoke hazards.
        for (int i = 0; i < 80; i++) begin
            ctrl_t c;
            c = ctrl_t'(11'($urandom));
            setInstr(1'($urandom_range(0, 3) != 0), c, 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            exFlush = ($urandom_range(0, 9) == 0);
            memHold = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end
        exFlush = 1'b0; memHold = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
